// File: rtl/decode_ctrl_stage_pkg.sv
// Shared RV32I decode constants, the registered control bundle and small helpers
// used by the ID-stage decoder and its immediate generator.
package decode_ctrl_stage_pkg;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_XOR   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_AND   = 4'h4;
    localparam logic [3:0] ALU_SLL   = 4'h5;
    localparam logic [3:0] ALU_SRL   = 4'h6;
    localparam logic [3:0] ALU_BEQ   = 4'h7;
    localparam logic [3:0] ALU_BNE   = 4'h8;
    localparam logic [3:0] ALU_SLT   = 4'h9;
    localparam logic [3:0] ALU_SRA   = 4'hA;
    localparam logic [3:0] ALU_AUIPC = 4'hB;
    localparam logic [3:0] ALU_BLT   = 4'hC;
    localparam logic [3:0] ALU_BGE   = 4'hD;
    localparam logic [3:0] ALU_JAL   = 4'hE;

    typedef enum logic {
        HZ_NORMAL,
        HZ_BUBBLE
    } hz_state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       cmp_unsigned;
        logic       mem_wen;
        logic [2:0] mem_size;
        logic       wb_sel;
        logic       reg_wb;
        logic       auipc;
        logic       branch;
        logic       jump;
        logic       pc_src;
        logic       illegal;
    } ctrl_t;

    // Quiet bundle: every enable off, sequential pc selected.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.pc_src = 1'b1;
        return c;
    endfunction

    // Mnemonics arrive NUL-padded on the left; turn that padding into spaces.
    function automatic logic [79:0] pad_ascii(input logic [79:0] s);
        logic [79:0] r;
        logic        seen;
        r    = s;
        seen = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (!seen && r[i*8 +: 8] == 8'h00) begin
                r[i*8 +: 8] = 8'h20;
            end else begin
                seen = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J field layout from the
// opcode and sign-extends it to XLEN. Shift-immediates yield the bare shamt.
module decode_ctrl_stage_imm_gen
    import decode_ctrl_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    imm32 = {26'd0, (XLEN == 64) ? instr_i[25] : 1'b0, instr_i[24:20]};
                end else begin
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            OP_LOAD, OP_JALR: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OP_STORE: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OP_BR: begin
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {instr_i[31:12], 12'd0};
            end
            OP_JAL: begin
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            default: begin
                imm32 = '0;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered ID stage: decodes one RV32I instruction per cycle into a control
// bundle, with valid/ready on both sides and one-bubble load-use stalling.
module decode_ctrl_stage
    import decode_ctrl_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit STR_EN   = 1'b1,
    parameter bit LU_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [3:0]      alu_ctrl,
    output logic            alu_src,
    output logic            cmp_unsigned,
    output logic            mem_wen,
    output logic [2:0]      mem_size,
    output logic            wb_sel,
    output logic            reg_wb,
    output logic            auipc,
    output logic            branch,
    output logic            jump,
    output logic            pc_src,
    output logic            illegal,
    output logic [79:0]     decode_str
);

    localparam logic [79:0] STR_RESET = STR_EN ? pad_ascii(80'("RESET")) : 80'd0;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           dec_d;
    logic [79:0]     name_d;
    logic [79:0]     str_d;
    logic [XLEN-1:0] imm_d;

    hz_state_e       state_q;
    hz_state_e       state_d;
    logic            out_valid_q;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;
    logic [79:0]     str_q;

    logic            load_hit;
    logic            stall_now;
    logic            accept;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    decode_ctrl_stage_imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr_i(instr),
        .imm_o  (imm_d)
    );

    always_comb begin
        dec_d         = ctrl_idle();
        dec_d.illegal = 1'b1;
        name_d        = 80'("ILLEGAL");
        case (opcode)
            OP_R: begin
                // funct7 may only be 0, or 0x20 for the SUB/SRA variants.
                if (!funct7[6] && funct7[4:0] == 5'd0 &&
                    (!funct7[5] || funct3 == 3'd0 || funct3 == 3'd5)) begin
                    dec_d.illegal = 1'b0;
                    dec_d.rs1     = instr[19:15];
                    dec_d.rs2     = instr[24:20];
                    dec_d.rd      = instr[11:7];
                    dec_d.reg_wb  = 1'b1;
                    case (funct3)
                        3'd0: begin
                            dec_d.alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                            name_d         = funct7[5] ? 80'("SUB") : 80'("ADD");
                        end
                        3'd1: begin dec_d.alu_ctrl = ALU_SLL; name_d = 80'("SLL"); end
                        3'd2: begin dec_d.alu_ctrl = ALU_SLT; name_d = 80'("SLT"); end
                        3'd3: begin
                            dec_d.alu_ctrl     = ALU_SLT;
                            dec_d.cmp_unsigned = 1'b1;
                            name_d             = 80'("SLTU");
                        end
                        3'd4: begin dec_d.alu_ctrl = ALU_XOR; name_d = 80'("XOR"); end
                        3'd5: begin
                            dec_d.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                            name_d         = funct7[5] ? 80'("SRA") : 80'("SRL");
                        end
                        3'd6: begin dec_d.alu_ctrl = ALU_OR; name_d = 80'("OR"); end
                        default: begin dec_d.alu_ctrl = ALU_AND; name_d = 80'("AND"); end
                    endcase
                end
            end
            OP_IMM: begin
                dec_d.illegal = 1'b0;
                dec_d.rs1     = instr[19:15];
                dec_d.rd      = instr[11:7];
                dec_d.alu_src = 1'b1;
                dec_d.reg_wb  = 1'b1;
                case (funct3)
                    3'd0: begin dec_d.alu_ctrl = ALU_ADD; name_d = 80'("ADDI"); end
                    3'd1: begin dec_d.alu_ctrl = ALU_SLL; name_d = 80'("SLLI"); end
                    3'd2: begin dec_d.alu_ctrl = ALU_SLT; name_d = 80'("SLTI"); end
                    3'd3: begin
                        dec_d.alu_ctrl     = ALU_SLT;
                        dec_d.cmp_unsigned = 1'b1;
                        name_d             = 80'("SLTIU");
                    end
                    3'd4: begin dec_d.alu_ctrl = ALU_XOR; name_d = 80'("XORI"); end
                    3'd5: begin
                        dec_d.alu_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
                        name_d         = instr[30] ? 80'("SRAI") : 80'("SRLI");
                    end
                    3'd6: begin dec_d.alu_ctrl = ALU_OR; name_d = 80'("ORI"); end
                    default: begin dec_d.alu_ctrl = ALU_AND; name_d = 80'("ANDI"); end
                endcase
            end
            OP_LOAD: begin
                if (funct3 != 3'd3 && funct3 <= 3'd5) begin
                    dec_d.illegal  = 1'b0;
                    dec_d.rs1      = instr[19:15];
                    dec_d.rd       = instr[11:7];
                    dec_d.alu_src  = 1'b1;
                    dec_d.wb_sel   = 1'b1;
                    dec_d.reg_wb   = 1'b1;
                    dec_d.mem_size = funct3;
                    case (funct3)
                        3'd0:    name_d = 80'("LB");
                        3'd1:    name_d = 80'("LH");
                        3'd2:    name_d = 80'("LW");
                        3'd4:    name_d = 80'("LBU");
                        default: name_d = 80'("LHU");
                    endcase
                end
            end
            OP_STORE: begin
                if (funct3 <= 3'd2) begin
                    dec_d.illegal  = 1'b0;
                    dec_d.rs1      = instr[19:15];
                    dec_d.rs2      = instr[24:20];
                    dec_d.alu_src  = 1'b1;
                    dec_d.mem_wen  = 1'b1;
                    dec_d.mem_size = funct3;
                    case (funct3)
                        3'd0:    name_d = 80'("SB");
                        3'd1:    name_d = 80'("SH");
                        default: name_d = 80'("SW");
                    endcase
                end
            end
            OP_BR: begin
                if (funct3 != 3'd2 && funct3 != 3'd3) begin
                    dec_d.illegal      = 1'b0;
                    dec_d.rs1          = instr[19:15];
                    dec_d.rs2          = instr[24:20];
                    dec_d.branch       = 1'b1;
                    dec_d.cmp_unsigned = funct3[1];
                    case (funct3)
                        3'd0:    begin dec_d.alu_ctrl = ALU_BEQ; name_d = 80'("BEQ"); end
                        3'd1:    begin dec_d.alu_ctrl = ALU_BNE; name_d = 80'("BNE"); end
                        3'd4:    begin dec_d.alu_ctrl = ALU_BLT; name_d = 80'("BLT"); end
                        3'd5:    begin dec_d.alu_ctrl = ALU_BGE; name_d = 80'("BGE"); end
                        3'd6:    begin dec_d.alu_ctrl = ALU_BLT; name_d = 80'("BLTU"); end
                        default: begin dec_d.alu_ctrl = ALU_BGE; name_d = 80'("BGEU"); end
                    endcase
                end
            end
            OP_JAL: begin
                dec_d.illegal  = 1'b0;
                dec_d.rd       = instr[11:7];
                dec_d.alu_ctrl = ALU_JAL;
                dec_d.alu_src  = 1'b1;
                dec_d.reg_wb   = 1'b1;
                dec_d.jump     = 1'b1;
                dec_d.pc_src   = 1'b0;
                name_d         = 80'("JAL");
            end
            OP_JALR: begin
                dec_d.illegal  = 1'b0;
                dec_d.rs1      = instr[19:15];
                dec_d.rd       = instr[11:7];
                dec_d.alu_ctrl = ALU_ADD;
                dec_d.alu_src  = 1'b1;
                dec_d.reg_wb   = 1'b1;
                dec_d.jump     = 1'b1;
                dec_d.pc_src   = 1'b0;
                name_d         = 80'("JALR");
            end
            OP_LUI: begin
                dec_d.illegal  = 1'b0;
                dec_d.rd       = instr[11:7];
                dec_d.alu_ctrl = ALU_ADD;
                dec_d.alu_src  = 1'b1;
                dec_d.reg_wb   = 1'b1;
                name_d         = 80'("LUI");
            end
            OP_AUIPC: begin
                dec_d.illegal  = 1'b0;
                dec_d.rd       = instr[11:7];
                dec_d.alu_ctrl = ALU_AUIPC;
                dec_d.alu_src  = 1'b1;
                dec_d.reg_wb   = 1'b1;
                dec_d.auipc    = 1'b1;
                name_d         = 80'("AUIPC");
            end
            default: begin
                dec_d.illegal = 1'b1;
            end
        endcase
        if (dec_d.rd == 5'd0) begin
            dec_d.reg_wb = 1'b0;
        end
    end

    assign str_d = STR_EN ? pad_ascii(name_d) : 80'd0;

    // Fields without a source register decode to index 0, and a hazard needs rd!=0.
    assign load_hit  = out_valid_q && ctrl_q.wb_sel && (ctrl_q.rd != 5'd0) && in_valid &&
                       ((dec_d.rs1 == ctrl_q.rd) || (dec_d.rs2 == ctrl_q.rd));
    assign stall_now = LU_STALL && (state_q == HZ_NORMAL) && load_hit;
    assign in_ready  = !reset && (!out_valid_q || out_ready) && !stall_now;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            HZ_NORMAL: begin
                if (stall_now && out_ready) begin
                    state_d = HZ_BUBBLE;
                end
            end
            HZ_BUBBLE: begin
                state_d = HZ_NORMAL;
            end
            default: begin
                state_d = HZ_NORMAL;
            end
        endcase
        if (flush) begin
            state_d = HZ_NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HZ_NORMAL;
            out_valid_q <= 1'b0;
            ctrl_q      <= ctrl_idle();
            pc_q        <= '0;
            imm_q       <= '0;
            str_q       <= STR_RESET;
        end else begin
            state_q <= state_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= dec_d;
                pc_q        <= pc;
                imm_q       <= imm_d;
                str_q       <= str_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = pc_q;
    assign imm          = imm_q;
    assign rs1          = ctrl_q.rs1;
    assign rs2          = ctrl_q.rs2;
    assign rd           = ctrl_q.rd;
    assign alu_ctrl     = ctrl_q.alu_ctrl;
    assign alu_src      = ctrl_q.alu_src;
    assign cmp_unsigned = ctrl_q.cmp_unsigned;
    assign mem_wen      = ctrl_q.mem_wen;
    assign mem_size     = ctrl_q.mem_size;
    assign wb_sel       = ctrl_q.wb_sel;
    assign reg_wb       = ctrl_q.reg_wb;
    assign auipc        = ctrl_q.auipc;
    assign branch       = ctrl_q.branch;
    assign jump         = ctrl_q.jump;
    assign pc_src       = ctrl_q.pc_src;
    assign illegal      = ctrl_q.illegal;
    assign decode_str   = str_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: hand-encoded instructions, each scenario
// in its own task with inline expected values.
module tb_decode_ctrl_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        cmp_unsigned;
    logic        mem_wen;
    logic [2:0]  mem_size;
    logic        wb_sel;
    logic        reg_wb;
    logic        auipc;
    logic        branch;
    logic        jump;
    logic        pc_src;
    logic        illegal;
    logic [79:0] decode_str;

    int checks;
    int fails;

    decode_ctrl_stage dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .imm         (imm),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .cmp_unsigned(cmp_unsigned),
        .mem_wen     (mem_wen),
        .mem_size    (mem_size),
        .wb_sel      (wb_sel),
        .reg_wb      (reg_wb),
        .auipc       (auipc),
        .branch      (branch),
        .jump        (jump),
        .pc_src      (pc_src),
        .illegal     (illegal),
        .decode_str  (decode_str)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [79:0] want_str;
        want_str  = "     RESET";
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;
        pc        = 32'h0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_in_ready_during: got %0d want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid_during: got %0d want 0", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %0d want 0", out_valid); end
        checks++; if (pc_src !== 1'b1) begin fails++; $display("[TB] FAIL rst_pc_src: got %0d want 1", pc_src); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready_after: got %0d want 1", in_ready); end
        checks++; if (reg_wb !== 1'b0) begin fails++; $display("[TB] FAIL rst_reg_wb: got %0d want 0", reg_wb); end
        checks++; if (decode_str !== want_str) begin fails++; $display("[TB] FAIL rst_str: got %s want %s", decode_str, want_str); end
    endtask

    task automatic test_stream();
        logic [79:0] want_str;
        want_str  = "      ADDI";
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h00500093;
        pc        = 32'h100;
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL addi_valid: got %0d want 1", out_valid); end
        checks++; if (alu_ctrl !== 4'h0) begin fails++; $display("[TB] FAIL addi_alu: got %0h want 0", alu_ctrl); end
        checks++; if (imm !== 32'd5) begin fails++; $display("[TB] FAIL addi_imm: got %0h want 5", imm); end
        checks++; if (rd !== 5'd1 || rs1 !== 5'd0) begin fails++; $display("[TB] FAIL addi_regs: got rd=%0d rs1=%0d want 1/0", rd, rs1); end
        checks++; if (alu_src !== 1'b1 || reg_wb !== 1'b1) begin fails++; $display("[TB] FAIL addi_ctl: got src=%0d wb=%0d want 1/1", alu_src, reg_wb); end
        checks++; if (out_pc !== 32'h100) begin fails++; $display("[TB] FAIL addi_pc: got %0h want 100", out_pc); end
        checks++; if (decode_str !== want_str) begin fails++; $display("[TB] FAIL addi_str: got %s want %s", decode_str, want_str); end
        instr = 32'h402081B3;
        pc    = 32'h104;
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL sub_valid: got %0d want 1", out_valid); end
        checks++; if (alu_ctrl !== 4'h1) begin fails++; $display("[TB] FAIL sub_alu: got %0h want 1", alu_ctrl); end
        checks++; if (imm !== 32'd0) begin fails++; $display("[TB] FAIL sub_imm: got %0h want 0", imm); end
        checks++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd3) begin fails++; $display("[TB] FAIL sub_regs: got %0d/%0d/%0d want 1/2/3", rs1, rs2, rd); end
        checks++; if (out_pc !== 32'h104) begin fails++; $display("[TB] FAIL sub_pc: got %0h want 104", out_pc); end
        instr = 32'h4020D213;
        pc    = 32'h108;
        step();
        checks++; if (alu_ctrl !== 4'hA) begin fails++; $display("[TB] FAIL srai_alu: got %0h want A", alu_ctrl); end
        checks++; if (imm !== 32'd2) begin fails++; $display("[TB] FAIL srai_imm: got %0h want 2", imm); end
        checks++; if (rs1 !== 5'd1 || rs2 !== 5'd0 || rd !== 5'd4) begin fails++; $display("[TB] FAIL srai_regs: got %0d/%0d/%0d want 1/0/4", rs1, rs2, rd); end
        checks++; if (out_pc !== 32'h108) begin fails++; $display("[TB] FAIL srai_pc: got %0h want 108", out_pc); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stream_drain: got %0d want 0", out_valid); end
    endtask

    task automatic test_load_use();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h0000A283;
        pc        = 32'h200;
        step();
        checks++; if (out_valid !== 1'b1 || wb_sel !== 1'b1) begin fails++; $display("[TB] FAIL lw_valid_wbsel: got %0d/%0d want 1/1", out_valid, wb_sel); end
        checks++; if (rd !== 5'd5 || mem_size !== 3'd2 || alu_ctrl !== 4'h0) begin fails++; $display("[TB] FAIL lw_fields: got rd=%0d size=%0d alu=%0h want 5/2/0", rd, mem_size, alu_ctrl); end
        instr = 32'h00528333;
        pc    = 32'h204;
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL lu_stall: got in_ready=%0d want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL lu_bubble: got out_valid=%0d want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL lu_release: got in_ready=%0d want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204) begin fails++; $display("[TB] FAIL add_issue: got valid=%0d pc=%0h want 1/204", out_valid, out_pc); end
        checks++; if (rd !== 5'd6 || rs1 !== 5'd5 || rs2 !== 5'd5) begin fails++; $display("[TB] FAIL add_regs: got %0d/%0d/%0d want 6/5/5", rd, rs1, rs2); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL lu_no_dup: got %0d want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h0020E3B3;
        pc        = 32'h300;
        step();
        checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'h3) begin fails++; $display("[TB] FAIL or_issue: got valid=%0d alu=%0h want 1/3", out_valid, alu_ctrl); end
        out_ready = 1'b0;
        instr     = 32'h0020C433;
        pc        = 32'h304;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready[%0d]: got %0d want 0", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || rd !== 5'd7 || out_pc !== 32'h300) begin fails++; $display("[TB] FAIL bp_hold[%0d]: got valid=%0d rd=%0d pc=%0h want 1/7/300", i, out_valid, rd, out_pc); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_release: got in_ready=%0d want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || rd !== 5'd8 || alu_ctrl !== 4'h2 || out_pc !== 32'h304) begin fails++; $display("[TB] FAIL xor_issue: got valid=%0d rd=%0d alu=%0h pc=%0h want 1/8/2/304", out_valid, rd, alu_ctrl, out_pc); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_dup: got %0d want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h00208463;
        pc        = 32'h400;
        step();
        checks++; if (branch !== 1'b1 || alu_ctrl !== 4'h7 || imm !== 32'd8) begin fails++; $display("[TB] FAIL beq_fields: got br=%0d alu=%0h imm=%0h want 1/7/8", branch, alu_ctrl, imm); end
        checks++; if (reg_wb !== 1'b0 || rd !== 5'd0) begin fails++; $display("[TB] FAIL beq_nowb: got wb=%0d rd=%0d want 0/0", reg_wb, rd); end
        instr = 32'h00100493;
        pc    = 32'h404;
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_kill: got out_valid=%0d want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_drop: got out_valid=%0d want 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [79:0] want_str;
        want_str  = "   ILLEGAL";
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'hFFFFFFFF;
        pc        = 32'h500;
        step();
        checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin fails++; $display("[TB] FAIL ones_illegal: got valid=%0d ill=%0d want 1/1", out_valid, illegal); end
        checks++; if (reg_wb !== 1'b0 || mem_wen !== 1'b0 || jump !== 1'b0) begin fails++; $display("[TB] FAIL ones_enables: got wb=%0d wen=%0d jmp=%0d want 0/0/0", reg_wb, mem_wen, jump); end
        checks++; if (decode_str !== want_str) begin fails++; $display("[TB] FAIL ones_str: got %s want %s", decode_str, want_str); end
        instr = 32'h0000008B;
        step();
        checks++; if (illegal !== 1'b1 || reg_wb !== 1'b0 || mem_wen !== 1'b0) begin fails++; $display("[TB] FAIL op0b: got ill=%0d wb=%0d wen=%0d want 1/0/0", illegal, reg_wb, mem_wen); end
        instr = 32'h0020B023;
        step();
        checks++; if (illegal !== 1'b1 || mem_wen !== 1'b0) begin fails++; $display("[TB] FAIL store_f3: got ill=%0d wen=%0d want 1/0", illegal, mem_wen); end
        instr = 32'h00100013;
        step();
        checks++; if (illegal !== 1'b0 || reg_wb !== 1'b0 || alu_src !== 1'b1) begin fails++; $display("[TB] FAIL addi_x0: got ill=%0d wb=%0d src=%0d want 0/0/1", illegal, reg_wb, alu_src); end
        instr = 32'h0000C503;
        step();
        checks++; if (illegal !== 1'b0 || mem_size !== 3'd4 || wb_sel !== 1'b1 || reg_wb !== 1'b1) begin fails++; $display("[TB] FAIL lbu: got ill=%0d size=%0d wbsel=%0d wb=%0d want 0/4/1/1", illegal, mem_size, wb_sel, reg_wb); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_jump();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h010000EF;
        pc        = 32'h600;
        step();
        checks++; if (jump !== 1'b1 || pc_src !== 1'b0 || alu_ctrl !== 4'hE) begin fails++; $display("[TB] FAIL jal_ctl: got jmp=%0d pcsrc=%0d alu=%0h want 1/0/E", jump, pc_src, alu_ctrl); end
        checks++; if (imm !== 32'd16 || rd !== 5'd1 || reg_wb !== 1'b1) begin fails++; $display("[TB] FAIL jal_fields: got imm=%0h rd=%0d wb=%0d want 10/1/1", imm, rd, reg_wb); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00500093;
        pc        = 32'h700;
        step();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mid_held: got %0d want 1", out_valid); end
        reset = 1'b1;
        flush = 1'b1;
        step();
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || pc_src !== 1'b1 || rd !== 5'd0 || reg_wb !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset: got valid=%0d pcsrc=%0d rd=%0d wb=%0d want 0/1/0/0", out_valid, pc_src, rd, reg_wb); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_stream();
        test_load_use();
        test_backpressure();
        test_flush();
        test_illegal();
        test_jump();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
